// File: rtl/rna_base_tx.sv
// rtl/rna_base_tx.sv - packed 2-bit base word to ASCII base stream serializer with danger freeze
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   in_valid   packed word available
//   in_ready   word accepted this cycle when in_valid is also high
//   in_word    NBASE packed 2-bit bases, base 0 in bits [1:0] goes out first
//   base       ASCII character of the current base, 8'h00 when base_valid is low
//   base_valid base holds a valid character
//   base_ready downstream consumes base this cycle
//   danger     alarm danger flag; freezes the block until reset
//   halted     block frozen by danger
//   sent_cnt   bases transferred since reset, wraps modulo 2^16
module rna_base_tx #(
    parameter int NBASE = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2*NBASE-1:0]   in_word,
    output logic [7:0]           base,
    output logic                 base_valid,
    input  logic                 base_ready,
    input  logic                 danger,
    output logic                 halted,
    output logic [15:0]          sent_cnt
);

    localparam int IW = $clog2(NBASE);
    localparam logic [IW-1:0] LAST_IDX = IW'(NBASE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_HALT
    } state_t;

    state_t               state_q, state_d;
    logic [2*NBASE-1:0]   shreg_q, shreg_d;
    logic [IW-1:0]        idx_q,   idx_d;
    logic [15:0]          cnt_q,   cnt_d;

    logic                 last_base;
    logic                 xfer;
    logic                 accept;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            shreg_q <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        base       = 8'h00;
        base_valid = 1'b0;
        halted     = (state_q == S_HALT);

        last_base = (idx_q == LAST_IDX);
        xfer      = (state_q == S_SEND) && base_ready;
        // Refilling only on the final base's transfer gives back-to-back words
        // without a bubble while never overwriting an unsent base.
        in_ready  = !danger && ((state_q == S_IDLE) ||
                                ((state_q == S_SEND) && last_base && base_ready));
        accept    = in_valid && in_ready;

        if (state_q == S_SEND) begin
            base_valid = 1'b1;
            case (shreg_q[1:0])
                2'b00:   base = 8'h41;
                2'b01:   base = 8'h43;
                2'b10:   base = 8'h47;
                default: base = 8'h54;
            endcase
        end

        if (xfer) begin
            cnt_d   = cnt_q + 16'd1;
            shreg_d = shreg_q >> 2;
            idx_d   = idx_q + 1'b1;
            if (last_base) begin
                state_d = S_IDLE;
            end
        end

        if (accept) begin
            shreg_d = in_word;
            idx_d   = '0;
            state_d = S_SEND;
        end

        // A base transferred on the danger edge was already consumed by the
        // alarm, so the counter update above stands; only the state freezes.
        if (danger && (state_q != S_HALT)) begin
            state_d = S_HALT;
        end
    end

    assign sent_cnt = cnt_q;

endmodule

// File: tb/tb_rna_base_tx.sv
// tb/tb_rna_base_tx.sv - scoreboard bench for rna_base_tx with directed vectors
module tb_rna_base_tx;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_word;
    logic [7:0]  base;
    logic        base_valid;
    logic        base_ready;
    logic        danger;
    logic        halted;
    logic [15:0] sent_cnt;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    logic [7:0] exp_26cc [8] = '{8'h41, 8'h54, 8'h41, 8'h54, 8'h47, 8'h43, 8'h47, 8'h41};

    rna_base_tx #(.NBASE(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_word    (in_word),
        .base       (base),
        .base_valid (base_valid),
        .base_ready (base_ready),
        .danger     (danger),
        .halted     (halted),
        .sent_cnt   (sent_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_26cc(input int n);
        for (int k = 0; k < n; k++) exp_q.push_back(exp_26cc[k]);
    endtask

    // Monitor: pops one expected base per transfer, and requires base=0 when idle.
    always @(negedge clk) begin
        if (reset) begin
            if (base_valid && base_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL stray_base: got %h expected none at %0t", base, $time);
                end else begin
                    chk("base", {24'h0, base}, {24'h0, exp_q.pop_front()});
                end
            end else if (!base_valid) begin
                chk("idle_base_zero", {24'h0, base}, 32'h0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b0;
        in_valid   = 1'b0;
        in_word    = 16'h0;
        base_ready = 1'b1;
        danger     = 1'b0;
        #12;
        chk("rst_base_valid", {31'h0, base_valid}, 32'h0);
        chk("rst_halted", {31'h0, halted}, 32'h0);
        chk("rst_sent_cnt", {16'h0, sent_cnt}, 32'h0);
        reset = 1'b1;
        step();
        chk("rst_in_ready", {31'h0, in_ready}, 32'h1);

        // 1: single word
        push_26cc(8);
        in_word  = 16'h26CC;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("t1_valid", {31'h0, base_valid}, 32'h1);
            step();
        end
        chk("t1_done_valid", {31'h0, base_valid}, 32'h0);
        chk("t1_sent_cnt", {16'h0, sent_cnt}, 32'd8);
        chk("t1_in_ready", {31'h0, in_ready}, 32'h1);

        // 2: back-to-back words
        push_26cc(8);
        for (int k = 0; k < 8; k++) exp_q.push_back(8'h43);
        in_word  = 16'h26CC;
        in_valid = 1'b1;
        step();
        in_word = 16'h5555;
        for (int i = 0; i < 16; i++) begin
            chk("t2_valid", {31'h0, base_valid}, 32'h1);
            chk("t2_in_ready", {31'h0, in_ready}, {31'h0, (i % 8) == 7});
            step();
            if (i == 7) in_valid = 1'b0;
        end
        chk("t2_done_valid", {31'h0, base_valid}, 32'h0);
        chk("t2_sent_cnt", {16'h0, sent_cnt}, 32'd24);

        // 3: backpressure on the third base
        push_26cc(8);
        in_word  = 16'h26CC;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        base_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t3_hold_base", {24'h0, base}, 32'h41);
            chk("t3_hold_valid", {31'h0, base_valid}, 32'h1);
            chk("t3_hold_cnt", {16'h0, sent_cnt}, 32'd26);
            chk("t3_in_ready", {31'h0, in_ready}, 32'h0);
            step();
        end
        base_ready = 1'b1;
        for (int i = 0; i < 6; i++) step();
        chk("t3_done_valid", {31'h0, base_valid}, 32'h0);
        chk("t3_sent_cnt", {16'h0, sent_cnt}, 32'd32);

        // 4: danger on the seventh base
        push_26cc(7);
        in_word  = 16'h26CC;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) step();
        chk("t4_seventh", {24'h0, base}, 32'h47);
        danger = 1'b1;
        step();
        chk("t4_sent_cnt", {16'h0, sent_cnt}, 32'd39);
        chk("t4_valid", {31'h0, base_valid}, 32'h0);
        chk("t4_base", {24'h0, base}, 32'h0);
        chk("t4_halted", {31'h0, halted}, 32'h1);
        chk("t4_in_ready", {31'h0, in_ready}, 32'h0);
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            danger     = i[0];
            base_ready = 1'($urandom_range(0, 1));
            step();
            chk("t4_frozen_valid", {31'h0, base_valid}, 32'h0);
            chk("t4_frozen_halted", {31'h0, halted}, 32'h1);
            chk("t4_frozen_cnt", {16'h0, sent_cnt}, 32'd39);
            chk("t4_frozen_in_ready", {31'h0, in_ready}, 32'h0);
        end
        in_valid   = 1'b0;
        danger     = 1'b0;
        base_ready = 1'b1;
        reset      = 1'b0;
        #1;
        chk("t4_rst_halted", {31'h0, halted}, 32'h0);
        chk("t4_rst_cnt", {16'h0, sent_cnt}, 32'h0);
        #2;
        reset = 1'b1;
        step();
        chk("t4_post_in_ready", {31'h0, in_ready}, 32'h1);

        // 5: async reset mid-word
        push_26cc(3);
        in_word  = 16'h26CC;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) step();
        chk("t5_pre_cnt", {16'h0, sent_cnt}, 32'd3);
        #2;
        reset = 1'b0;
        #1;
        chk("t5_rst_valid", {31'h0, base_valid}, 32'h0);
        chk("t5_rst_base", {24'h0, base}, 32'h0);
        chk("t5_rst_cnt", {16'h0, sent_cnt}, 32'h0);
        @(negedge clk);
        #1;
        reset = 1'b1;
        step();
        chk("t5_in_ready", {31'h0, in_ready}, 32'h1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t5_no_stray", {31'h0, base_valid}, 32'h0);
        end
        chk("t5_queue_empty", exp_q.size(), 32'h0);

        // 6: danger in IDLE blocks the accept
        in_word  = 16'h5555;
        in_valid = 1'b1;
        danger   = 1'b1;
        #1;
        chk("t6_in_ready", {31'h0, in_ready}, 32'h0);
        step();
        danger = 1'b0;
        chk("t6_halted", {31'h0, halted}, 32'h1);
        for (int i = 0; i < 5; i++) begin
            chk("t6_valid", {31'h0, base_valid}, 32'h0);
            chk("t6_in_ready_halt", {31'h0, in_ready}, 32'h0);
            step();
        end
        chk("t6_sent_cnt", {16'h0, sent_cnt}, 32'h0);
        chk("final_queue_empty", exp_q.size(), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
